// File: rtl/sp_ram_arbiter.sv
// Round-robin, burst-limited arbiter/sequencer for one single-port synchronous RAM.
// Define ARB_FIXED_PRIO_EN to give port 0 strict priority instead.
module sp_ram_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               req0,
    input  logic                               we0,
    input  logic [AW-1:0]                      addr0,
    input  logic [DW-1:0]                      wdata0,
    output logic                               gnt0,
    output logic                               rvalid0,
    output logic [DW-1:0]                      rdata0,
    input  logic                               req1,
    input  logic                               we1,
    input  logic [AW-1:0]                      addr1,
    input  logic [DW-1:0]                      wdata1,
    output logic                               gnt1,
    output logic                               rvalid1,
    output logic [DW-1:0]                      rdata1,
    output logic                               ram_en,
    output logic                               ram_we,
    output logic [AW-1:0]                      ram_addr,
    output logic [DW-1:0]                      ram_di,
    input  logic [DW-1:0]                      ram_do,
    output logic [1:0]                         dbg_state_o,
    output logic [$clog2(MAX_BURST+1)-1:0]     dbg_burst_o
);
    // Handshake: a transfer on port k happens in any cycle where reqk & gntk is
    // high at the rising edge; the requester holds its command until then.
    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          last_q, last_d;
    logic          en_q, we_q, tag_q, rv0_q, rv1_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] di_q;
    logic          g0, g1;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        g0 = req0;
        g1 = req1 & ~req0;
`else
        case (state_q)
            OWN0: begin
                if (req0 && (burst_q < MAX_C || !req1)) g0 = 1'b1;
                else if (req1)                          g1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (burst_q < MAX_C || !req0)) g1 = 1'b1;
                else if (req0)                          g0 = 1'b1;
            end
            default: begin
                // On a tie the port that did not transfer last wins.
                if (req0 && (!req1 || last_q)) g0 = 1'b1;
                else if (req1)                 g1 = 1'b1;
            end
        endcase
`endif
        if (!RST_N) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    always_comb begin
        state_d = IDLE;
        burst_d = '0;
        last_d  = last_q;
        if (g0 || g1) begin
            state_d = g1 ? OWN1 : OWN0;
            last_d  = g1;
            if (state_q == state_d)
                burst_d = (burst_q == MAX_C) ? MAX_C : burst_q + CW'(1);
            else
                burst_d = CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= 1'b1;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            tag_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            rv0_q   <= en_q & ~we_q & ~tag_q;
            rv1_q   <= en_q & ~we_q &  tag_q;
            if (g0 || g1) begin
                en_q   <= 1'b1;
                we_q   <= g1 ? we1 : we0;
                addr_q <= g1 ? addr1 : addr0;
                di_q   <= g1 ? wdata1 : wdata0;
                tag_q  <= g1;
            end else begin
                en_q <= 1'b0;
                we_q <= 1'b0;
            end
        end
    end

    assign gnt0        = g0;
    assign gnt1        = g1;
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign ram_addr    = addr_q;
    assign ram_di      = di_q;
    assign rvalid0     = rv0_q;
    assign rvalid1     = rv1_q;
    assign rdata0      = ram_do;
    assign rdata1      = ram_do;
    assign dbg_state_o = state_q;
    assign dbg_burst_o = burst_q;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: transaction-level model plus directed literal checks.
module tb_sp_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_di;
    logic [DW-1:0] ram_do = '0;
    logic [AW-1:0] ram_addr;
    logic [1:0]    dbg_state;
    logic [2:0]    dbg_burst;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    sp_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do),
        .dbg_state_o(dbg_state), .dbg_burst_o(dbg_burst)
    );

    // Write-first single-port RAM with one cycle of read latency.
    logic [DW-1:0] mem [64];
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do        <= ram_di;
            end else begin
                ram_do <= mem[ram_addr];
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: who should win this cycle, from ownership, run length and tie history.
    function automatic int exp_grant(int owner, int run, int last, logic r0, logic r1);
        if (!r0 && !r1) return 2;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (owner == 2) return (last == 1) ? 0 : 1;
        if (run < MB)   return owner;
        return 1 - owner;
    endfunction

    int            m_owner = 2, m_run = 0, m_last = 1;
    bit            started = 0;
    logic          m_en = 0, m_we = 0, m_tag = 0, e_rv0 = 0, e_rv1 = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_di = '0, m_rdv = '0, e_rdata = '0;
    logic [DW-1:0] shadow [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
    end

    always @(negedge CLK) begin
        int eg;
        eg = RST_N ? exp_grant(m_owner, m_run, m_last, req0, req1) : 2;
        if (started) begin
            chk("gnt0", {31'd0, gnt0}, {31'd0, eg == 0});
            chk("gnt1", {31'd0, gnt1}, {31'd0, eg == 1});
            chk("ram_en", {31'd0, ram_en}, {31'd0, m_en});
            chk("ram_we", {31'd0, ram_we}, {31'd0, m_we});
            chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            chk("ram_di", 32'(ram_di), 32'(m_di));
            chk("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv0});
            chk("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv1});
            if (e_rv0) chk("rdata0", 32'(rdata0), 32'(e_rdata));
            if (e_rv1) chk("rdata1", 32'(rdata1), 32'(e_rdata));
            chk("burst_cnt", 32'(dbg_burst), 32'(m_run));
        end
        if (!RST_N) begin
            started = 1;
            m_owner = 2; m_run = 0; m_last = 1;
            m_en = 0; m_we = 0; m_addr = '0; m_di = '0; m_tag = 0;
            e_rv0 = 0; e_rv1 = 0;
        end else begin
            e_rv0   = m_en & ~m_we & ~m_tag;
            e_rv1   = m_en & ~m_we &  m_tag;
            e_rdata = m_rdv;
            if (eg != 2) begin
                m_run   = (m_owner == eg) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
                m_owner = eg;
                m_last  = eg;
                m_en    = 1;
                m_tag   = (eg == 1);
                m_we    = (eg == 1) ? we1 : we0;
                m_addr  = (eg == 1) ? addr1 : addr0;
                m_di    = (eg == 1) ? wdata1 : wdata0;
                m_rdv   = shadow[m_addr];
                if (m_we) shadow[m_addr] = m_di;
            end else begin
                m_owner = 2; m_run = 0;
                m_en = 0; m_we = 0;
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        summary();
        $finish;
    end

    initial begin
        int seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        int got;
        bit g0s, g1s;

        // Reset held with both ports requesting.
        RST_N = 0;
        req0 = 1; we0 = 1; addr0 = 6'd2; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 6'd3; wdata1 = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rst_gnt0", {31'd0, gnt0}, 0);
            chk("rst_gnt1", {31'd0, gnt1}, 0);
            chk("rst_ram_en", {31'd0, ram_en}, 0);
            chk("rst_rvalid0", {31'd0, rvalid0}, 0);
            chk("rst_rvalid1", {31'd0, rvalid1}, 0);
        end

        // Contention from idle: bursts of four, port 0 first, no idle cycles.
        RST_N = 1; #1;
        for (int i = 0; i < 12; i++) begin
            got = gnt1 ? 1 : (gnt0 ? 0 : 2);
            chk("cont_seq", 32'(got), 32'(seq[i]));
            cyc(); #1;
        end
        req0 = 0; req1 = 0;
        cyc(2);

        // Port 0 writes 0xBEEF to addr 5, then reads it back.
        req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 16'hBEEF; #1;
        chk("wr_gnt0", {31'd0, gnt0}, 1);
        cyc();
        we0 = 0; #1;
        chk("wr_cmd_en", {31'd0, ram_en}, 1);
        chk("wr_cmd_we", {31'd0, ram_we}, 1);
        chk("wr_cmd_addr", 32'(ram_addr), 5);
        chk("wr_cmd_di", 32'(ram_di), 32'hBEEF);
        chk("rd_gnt0", {31'd0, gnt0}, 1);
        cyc();
        req0 = 0;
        cyc(); #1;
        chk("rd_rvalid0", {31'd0, rvalid0}, 1);
        chk("rd_rdata0", 32'(rdata0), 32'hBEEF);
        chk("rd_rvalid1", {31'd0, rvalid1}, 0);
        cyc(2);

        // Port 1 alone for 10 cycles: never stalled, burst count saturates.
        req1 = 1; we1 = 1;
        for (int i = 0; i < 10; i++) begin
            addr1 = 6'(10 + i); wdata1 = 16'(16'h0100 + i); #1;
            chk("solo_gnt1", {31'd0, gnt1}, 1);
            chk("solo_burst", 32'(dbg_burst), 32'((i < 4) ? i : 4));
            cyc();
        end
        req1 = 0; #1;
        chk("solo_burst_sat", 32'(dbg_burst), 4);
        cyc(2);

        // Read routing: port 0 reads addr 2, port 1 reads addr 3 one cycle later.
        req0 = 1; we0 = 0; addr0 = 6'd2; #1;
        chk("rt_gnt0", {31'd0, gnt0}, 1);
        cyc();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 6'd3; #1;
        chk("rt_gnt1", {31'd0, gnt1}, 1);
        cyc();
        req1 = 0; #1;
        chk("rt_rvalid0", {31'd0, rvalid0}, 1);
        chk("rt_rdata0", 32'(rdata0), 32'h1111);
        chk("rt_rvalid1_early", {31'd0, rvalid1}, 0);
        cyc(); #1;
        chk("rt_rvalid1", {31'd0, rvalid1}, 1);
        chk("rt_rdata1", 32'(rdata1), 32'h2222);
        chk("rt_rvalid0_late", {31'd0, rvalid0}, 0);
        cyc();

        // Reset while a port 0 read is in flight.
        req0 = 1; we0 = 0; addr0 = 6'd2; #1;
        chk("mr_gnt0", {31'd0, gnt0}, 1);
        cyc();
        req0 = 0; RST_N = 0;
        cyc();
        RST_N = 1; #1;
        chk("mr_rvalid0", {31'd0, rvalid0}, 0);
        chk("mr_rvalid1", {31'd0, rvalid1}, 0);
        chk("mr_ram_en", {31'd0, ram_en}, 0);
        req0 = 1; we0 = 1; wdata0 = 16'h3333; addr0 = 6'd30;
        req1 = 1; we1 = 1; wdata1 = 16'h4444; addr1 = 6'd31; #1;
        chk("mr_tie_gnt0", {31'd0, gnt0}, 1);
        chk("mr_tie_gnt1", {31'd0, gnt1}, 0);
        cyc(); #1;
        chk("mr_rvalid0_after", {31'd0, rvalid0}, 0);
        cyc(3);
        req0 = 0; req1 = 0;
        cyc(2);

        // Interleaved reads and writes on a few shared addresses under contention.
        req0 = 1; we0 = 1; addr0 = 6'd20; wdata0 = 16'h5A00;
        req1 = 1; we1 = 0; addr1 = 6'd20; wdata1 = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            #1;
            g0s = gnt0; g1s = gnt1;
            cyc();
            if (g0s) begin
                we0 = 1'($urandom_range(0, 1));
                addr0 = 6'($urandom_range(20, 23));
                wdata0 = 16'($urandom_range(0, 65535));
            end
            if (g1s) begin
                we1 = 1'($urandom_range(0, 1));
                addr1 = 6'($urandom_range(20, 23));
                wdata1 = 16'($urandom_range(0, 65535));
            end
        end
        req0 = 0; req1 = 0;
        cyc(4);

        summary();
        $finish;
    end
endmodule
